// File: rtl/pong_pkg.sv
// pong_pkg: definitions shared by the paddle controllers and the renderer.
//   ROWS / ROW_W : screen height in rows and the width of a row index
//   quad_t       : quadrature pin states, named by their {A,B} value
//   gray_idx()   : position of a quadrature state in the forward Gray cycle
//   row_mask()   : 16-bit mask with rows pos..pos+len-1 set
package pong_pkg;

    localparam int unsigned ROWS  = 16;
    localparam int unsigned ROW_W = 4;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } quad_t;

    // Forward rotation visits 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] gray_idx(input quad_t q);
        case (q)
            Q00:     gray_idx = 2'd0;
            Q01:     gray_idx = 2'd1;
            Q11:     gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    function automatic logic [ROWS-1:0] row_mask(input logic [ROW_W-1:0] pos,
                                                 input int unsigned len);
        int unsigned p;
        logic [ROWS-1:0] m;
        p = 32'(pos);
        m = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            m[i] = (i >= p) && (i < p + len);
        end
        return m;
    endfunction

endpackage

// File: rtl/paddle_if.sv
// paddle_if: paddle-mask bus between a paddle controller and the ball logic.
//   ball_y : ball vertical position from the ball logic ([7:4] is the row)
//   pos    : top row of the paddle
//   paddle : row occupancy mask, one bit per screen row
// master = paddle controller (producer), slave = ball logic (consumer).
interface paddle_if import pong_pkg::*; ();

    logic [7:0]       ball_y;
    logic [ROW_W-1:0] pos;
    logic [ROWS-1:0]  paddle;

    modport master (input ball_y, output pos, output paddle);
    modport slave  (output ball_y, input pos, input paddle);

endinterface

// File: rtl/paddle_quad_decoder.sv
// quad_decoder: rotary encoder front end.
//   clk, reset       : game clock, synchronous active-high reset
//   enc_a, enc_b     : raw asynchronous encoder phases
//   clear_acc        : holds the detent accumulator at 0 and suppresses steps
//   step_up          : one-cycle pulse, one detent in the reverse direction
//   step_down        : one-cycle pulse, one detent in the forward direction
// Pins pass a two-flop synchronizer, then a stability filter, then a Gray
// direction decoder feeding a signed detent accumulator.
module quad_decoder import pong_pkg::*; #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned STEPS    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic clear_acc,
    output logic step_up,
    output logic step_down
);

    localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic signed [3:0] STEPS_POS = 4'(STEPS);
    localparam logic signed [3:0] STEPS_NEG = -STEPS_POS;

    logic [1:0]        s1_q, s1_d;
    logic [1:0]        s2_q, s2_d;
    logic [1:0]        deb_q, deb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic signed [3:0] acc_q, acc_d;
    logic              step_up_q, step_up_d;
    logic              step_down_q, step_down_d;
    logic              deb_upd;
    logic [1:0]        dir;

    always_comb begin
        s1_d        = {enc_a, enc_b};
        s2_d        = s1_q;
        deb_d       = deb_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        step_up_d   = 1'b0;
        step_down_d = 1'b0;
        deb_upd     = 1'b0;

        // s1 != s2 means s2 is about to change, which restarts the filter.
        if (s2_q == deb_q || s1_q != s2_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
            cnt_d   = '0;
            deb_d   = s2_q;
            deb_upd = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Distance along the Gray cycle: 1 = forward, 3 = reverse,
        // 2 = both bits flipped (direction unknown, ignored).
        dir = gray_idx(quad_t'(s2_q)) - gray_idx(quad_t'(deb_q));

        if (clear_acc) begin
            acc_d = '0;
        end else if (deb_upd) begin
            if (dir == 2'd1) begin
                if (acc_q + 4'sd1 == STEPS_POS) begin
                    acc_d       = '0;
                    step_down_d = 1'b1;
                end else begin
                    acc_d = acc_q + 4'sd1;
                end
            end else if (dir == 2'd3) begin
                if (acc_q - 4'sd1 == STEPS_NEG) begin
                    acc_d     = '0;
                    step_up_d = 1'b1;
                end else begin
                    acc_d = acc_q - 4'sd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= 2'b11;
            s2_q        <= 2'b11;
            deb_q       <= 2'b11;
            cnt_q       <= '0;
            acc_q       <= '0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            deb_q       <= deb_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
        end
    end

    assign step_up   = step_up_q;
    assign step_down = step_down_q;

endmodule

// File: rtl/paddle.sv
// paddle: player paddle controller, producer side of paddle_if.
//   clk, reset   : game clock, synchronous active-high reset
//   enc_a, enc_b : quadrature encoder phases (asynchronous)
//   auto_en      : 1 = paddle tracks the ball row, encoder steps ignored
//   pif          : paddle_if master (ball_y in, pos / paddle out)
// pos saturates at 0 and ROWS-LEN; paddle is registered alongside pos.
module paddle import pong_pkg::*; #(
    parameter int unsigned LEN      = 3,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned STEPS    = 4,
    parameter int unsigned AUTO_DIV = 64
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      enc_a,
    input  logic      enc_b,
    input  logic      auto_en,
    paddle_if.master  pif
);

    localparam int unsigned POS_MAX = ROWS - LEN;
    localparam int unsigned POS_RST = (ROWS - LEN) / 2;
    localparam int unsigned DIV_W   = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

    logic [ROW_W-1:0] pos_q, pos_d;
    logic [ROWS-1:0]  paddle_q, paddle_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             step_up, step_down;
    logic [ROW_W-1:0] target;
    int               t;

    quad_decoder #(
        .DEBOUNCE (DEBOUNCE),
        .STEPS    (STEPS)
    ) u_dec (
        .clk       (clk),
        .reset     (reset),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .clear_acc (auto_en),
        .step_up   (step_up),
        .step_down (step_down)
    );

    // Auto target centres the paddle on the ball row, clamped to the screen.
    always_comb begin
        t = int'(pif.ball_y[7:4]) - int'(LEN / 2);
        if (t < 0) begin
            t = 0;
        end else if (t > int'(POS_MAX)) begin
            t = int'(POS_MAX);
        end
        target = ROW_W'(t);
    end

    always_comb begin
        pos_d = pos_q;
        div_d = div_q;
        if (!auto_en) begin
            div_d = '0;
            if (step_up && pos_q != '0) begin
                pos_d = pos_q - 1'b1;
            end else if (step_down && pos_q != ROW_W'(POS_MAX)) begin
                pos_d = pos_q + 1'b1;
            end
        end else if (div_q == DIV_W'(AUTO_DIV - 1)) begin
            div_d = '0;
            if (target > pos_q) begin
                pos_d = pos_q + 1'b1;
            end else if (target < pos_q) begin
                pos_d = pos_q - 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
        paddle_d = row_mask(pos_d, LEN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q    <= ROW_W'(POS_RST);
            paddle_q <= row_mask(ROW_W'(POS_RST), LEN);
            div_q    <= '0;
        end else begin
            pos_q    <= pos_d;
            paddle_q <= paddle_d;
            div_q    <= div_d;
        end
    end

    assign pif.pos    = pos_q;
    assign pif.paddle = paddle_q;

endmodule

// File: tb/tb_paddle.sv
// tb_paddle: directed-vector bench for paddle (LEN=3, DEBOUNCE=4, STEPS=4,
// AUTO_DIV=64). Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point after the following edges.
module tb_paddle;

    logic clk;
    logic reset;
    logic enc_a;
    logic enc_b;
    logic auto_en;
    int   tests;
    int   fails;
    int   lat;

    paddle_if pif();

    paddle #(
        .LEN      (3),
        .DEBOUNCE (4),
        .STEPS    (4),
        .AUTO_DIV (64)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .auto_en (auto_en),
        .pif     (pif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // LEN=3 paddle: mask is 3'b111 shifted to the top row.
    task automatic check_pos(input string tag, input int p);
        logic [15:0] m;
        m = 16'h0007 << p;
        check({tag, "_pos"}, 32'(pif.pos), 32'(p));
        check({tag, "_mask"}, 32'(pif.paddle), 32'(m));
    endtask

    task automatic seq(input logic [1:0] v);
        {enc_a, enc_b} = v;
        tick(8);
    endtask

    task automatic cw();
        seq(2'b10); seq(2'b00); seq(2'b01); seq(2'b11);
    endtask

    task automatic ccw();
        seq(2'b01); seq(2'b00); seq(2'b10); seq(2'b11);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {enc_a, enc_b} = 2'b11;
        auto_en = 1'b0;
        pif.ball_y = 8'h00;
        tick(3);
        reset = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset state and idle hold
        do_reset();
        check("rst_pos", 32'(pif.pos), 32'd6);
        check("rst_mask", 32'(pif.paddle), 32'h01C0);
        tick(100);
        check_pos("idle", 6);

        // One CW detent with latency measurement on the final pin change
        seq(2'b10); seq(2'b00); seq(2'b01);
        check_pos("cw_partial", 6);
        {enc_a, enc_b} = 2'b11;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (pif.pos != 4'd6 && lat == 0) lat = k;
        end
        check("cw_latency", 32'(lat), 32'd7);
        check("cw1_mask_const", 32'(pif.paddle), 32'h0380);
        check_pos("cw1", 7);
        for (int i = 0; i < 4; i++) ccw();
        check_pos("ccw4", 3);

        // Bounce on A for 3 clocks settling at 10, then finish the detent
        {enc_a, enc_b} = 2'b10; tick(1);
        {enc_a, enc_b} = 2'b11; tick(1);
        {enc_a, enc_b} = 2'b10; tick(1);
        tick(8);
        seq(2'b00); seq(2'b01); seq(2'b11);
        check_pos("bounce", 4);
        // Short glitches returning to 11
        {enc_a, enc_b} = 2'b01; tick(2);
        {enc_a, enc_b} = 2'b11; tick(10);
        check_pos("glitch2", 4);
        {enc_a, enc_b} = 2'b10; tick(3);
        {enc_a, enc_b} = 2'b11; tick(10);
        check_pos("glitch3", 4);
        cw();
        check_pos("after_glitch", 5);

        // Saturation at both ends
        do_reset();
        for (int i = 0; i < 12; i++) cw();
        check_pos("sat_hi", 13);
        check("sat_hi_const", 32'(pif.paddle), 32'hE000);
        for (int i = 0; i < 20; i++) ccw();
        check_pos("sat_lo", 0);
        check("sat_lo_const", 32'(pif.paddle), 32'h0007);

        // Reset mid-detent drops accumulated transitions
        seq(2'b10); seq(2'b00); seq(2'b01);
        do_reset();
        check_pos("rst_mid", 6);
        cw();
        check_pos("rst_mid_cw", 7);

        // Invalid double-bit jumps do not count
        seq(2'b00); seq(2'b11);
        check_pos("invalid", 7);
        cw();
        check_pos("invalid_cw", 8);

        // Half detent forward then back leaves acc at 0
        seq(2'b10); seq(2'b00); seq(2'b10); seq(2'b11);
        check_pos("half", 8);
        cw();
        check_pos("half_cw", 9);

        // Auto mode toward ball row 15 -> target 13
        do_reset();
        pif.ball_y = 8'hF0;
        auto_en = 1'b1;
        tick(63);
        check_pos("auto_63", 6);
        tick(1);
        check_pos("auto_64", 7);
        tick(64);
        check_pos("auto_128", 8);
        for (int i = 0; i < 12; i++) ccw();
        check_pos("auto_end", 13);

        // Leave auto mid-detent: first two CCW transitions must be forgotten
        seq(2'b01); seq(2'b00);
        auto_en = 1'b0;
        seq(2'b10); seq(2'b11);
        check_pos("auto_off_partial", 13);
        ccw();
        check_pos("auto_off_ccw", 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
